// File: rtl/fb_pkg.sv
// Shared constants, opcodes and FSM encoding for the framebuffer draw sequencer.
package fb_pkg;
    localparam int FB_W         = 320;
    localparam int FB_H         = 200;
    localparam int N_BANKS      = 4;
    localparam int BANK_AW      = 14;
    localparam int BANK_SEL_MSB = 15;
    localparam int BANK_SEL_LSB = 14;

    localparam logic [8:0]  X_MAX    = 9'(FB_W - 1);
    localparam logic [7:0]  Y_MAX    = 8'(FB_H - 1);
    localparam logic [15:0] ROW_STEP = 16'(FB_W);

    typedef enum logic [1:0] {
        OP_PLOT  = 2'b00,
        OP_RECT  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [8:0] x0;
        logic [7:0] y0;
        logic [8:0] x1;
        logic [7:0] y1;
    } rect_t;

    // y*320 as two shifts; only valid for the 320-pixel-wide layout.
    function automatic logic [15:0] row_base(input logic [7:0] y);
        return {y, 8'b0} + {2'b0, y, 6'b0};
    endfunction
endpackage

// File: rtl/fb_raster_walk.sv
// Raster-order walker over an inclusive rectangle: x/y counters, running row base, last flag.
module fb_raster_walk
    import fb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        step_i,
    input  rect_t       rect_i,
    output logic [15:0] addr_o,
    output logic        last_o
);
    logic [8:0]  x_q, x0_q, x1_q;
    logic [7:0]  y_q, y1_q;
    logic [15:0] row_q;
    logic        x_end;

    assign x_end  = (x_q == x1_q);
    assign last_o = x_end && (y_q == y1_q);
    assign addr_o = row_q + {7'b0, x_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            x0_q  <= '0;
            x1_q  <= '0;
            y_q   <= '0;
            y1_q  <= '0;
            row_q <= '0;
        end else if (load_i) begin
            x_q   <= rect_i.x0;
            x0_q  <= rect_i.x0;
            x1_q  <= rect_i.x1;
            y_q   <= rect_i.y0;
            y1_q  <= rect_i.y1;
            row_q <= row_base(rect_i.y0);
        end else if (step_i) begin
            if (x_end) begin
                x_q   <= x0_q;
                y_q   <= y_q + 8'd1;
                row_q <= row_q + ROW_STEP;
            end else begin
                x_q   <= x_q + 9'd1;
            end
        end
    end
endmodule

// File: rtl/fb_draw_ctrl.sv
// Drawing-command sequencer: accepts PLOT/RECT/CLEAR/NOP and writes one pixel per cycle
// into the four-bank framebuffer write port.
module fb_draw_ctrl
    import fb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [8:0]         cmd_x0,
    input  logic [7:0]         cmd_y0,
    input  logic [8:0]         cmd_x1,
    input  logic [7:0]         cmd_y1,
    input  logic               cmd_color,
    output logic [N_BANKS-1:0] fb_we,
    output logic [BANK_AW-1:0] fb_addr,
    output logic               fb_din,
    output logic               busy,
    output logic               done
);
    state_e             state_q, state_d;
    op_e                op_q;
    logic [8:0]         x0_q, x1_q;
    logic [7:0]         y0_q, y1_q;
    logic               color_q;
    logic               ready_q, done_q;
    logic [N_BANKS-1:0] we_q;
    logic [BANK_AW-1:0] addr_q;
    logic               din_q;

    logic               accept;
    logic               empty;
    rect_t              rect;
    logic [15:0]        waddr;
    logic               last;

    assign accept = (state_q == S_IDLE) && ready_q && cmd_valid;

    // Rectangle as seen by the walker; only meaningful while in SETUP.
    always_comb begin
        rect = '{x0: x0_q, y0: y0_q, x1: x1_q, y1: y1_q};
        case (op_q)
            OP_CLEAR: rect = '{x0: 9'd0, y0: 8'd0, x1: X_MAX, y1: Y_MAX};
            OP_PLOT: begin
                rect.x1 = x0_q;
                rect.y1 = y0_q;
            end
            OP_RECT: begin
                if (x1_q > X_MAX) rect.x1 = X_MAX;
                if (y1_q > Y_MAX) rect.y1 = Y_MAX;
            end
            default: ;
        endcase
        empty = (op_q == OP_NOP) || (rect.x0 > rect.x1) || (rect.y0 > rect.y1)
             || (rect.x0 > X_MAX) || (rect.y0 > Y_MAX);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_SETUP;
            S_SETUP: state_d = empty ? S_DONE : S_RUN;
            S_RUN:   if (last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    fb_raster_walk u_walk (
        .clk    (clk),
        .rst_n  (reset),
        .load_i (state_q == S_SETUP),
        .step_i (state_q == S_RUN),
        .rect_i (rect),
        .addr_o (waddr),
        .last_o (last)
    );

    // Outputs are registered one cycle behind the FSM, so ready returns only after the done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_PLOT;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            color_q <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= '0;
            addr_q  <= '0;
            din_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_q == S_IDLE) && !accept;
            done_q  <= (state_q == S_DONE);
            if (accept) begin
                op_q    <= op_e'(cmd_op);
                x0_q    <= cmd_x0;
                x1_q    <= cmd_x1;
                y0_q    <= cmd_y0;
                y1_q    <= cmd_y1;
                color_q <= cmd_color;
            end
            if (state_q == S_RUN) begin
                we_q   <= {{(N_BANKS-1){1'b0}}, 1'b1} << waddr[BANK_SEL_MSB:BANK_SEL_LSB];
                addr_q <= waddr[BANK_AW-1:0];
                din_q  <= color_q;
            end else begin
                we_q   <= '0;
            end
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = (state_q != S_IDLE) || done_q;
    assign done      = done_q;
    assign fb_we     = we_q;
    assign fb_addr   = addr_q;
    assign fb_din    = din_q;
endmodule

// File: tb/tb_fb_draw_ctrl.sv
// Directed bench for fb_draw_ctrl with a write scoreboard fed from a pixel model.
module tb_fb_draw_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [8:0] cmd_x0 = '0, cmd_x1 = '0;
    logic [7:0] cmd_y0 = '0, cmd_y1 = '0;
    logic       cmd_color = 1'b0;
    logic       cmd_ready, fb_din, busy, done;
    logic [3:0] fb_we;
    logic [13:0] fb_addr;

    typedef struct packed {
        logic [3:0]  we;
        logic [13:0] addr;
        logic        din;
    } wr_t;

    wr_t sb[$];
    int  tests = 0;
    int  fails = 0;
    int  n_wr  = 0;

    always #5 clk = ~clk;

    fb_draw_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_din    (fb_din),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every write on port B must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t o, e;
        if (reset && fb_we != 4'b0) begin
            o = '{we: fb_we, addr: fb_addr, din: fb_din};
            n_wr++;
            chk("write_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("write", o, e);
            end
        end
    end

    task automatic push_exp(input int a, input logic c);
        sb.push_back('{we: 4'(1 << (a >> 14)), addr: 14'(a & 16383), din: c});
    endtask

    task automatic push_model(input logic [1:0] op, input int x0, input int y0,
                              input int x1, input int y1, input logic c, output int n);
        int lx, ly, hx, hy;
        n = 0;
        if (op == 2'b11) return;
        lx = x0; ly = y0; hx = x1; hy = y1;
        if (op == 2'b10) begin
            lx = 0; ly = 0; hx = 319; hy = 199;
        end else if (op == 2'b00) begin
            hx = x0; hy = y0;
        end else begin
            if (hx > 319) hx = 319;
            if (hy > 199) hy = 199;
        end
        if (lx > hx || ly > hy || lx > 319 || ly > 199) return;
        for (int y = ly; y <= hy; y++)
            for (int x = lx; x <= hx; x++) begin
                push_exp(y * 320 + x, c);
                n++;
            end
    endtask

    // Returns just after the accepting edge, with inputs scrambled to prove they are ignored.
    task automatic issue(input logic [1:0] op, input int x0, input int y0,
                         input int x1, input int y1, input logic c);
        int w;
        @(negedge clk);
        cmd_op = op; cmd_x0 = 9'(x0); cmd_y0 = 8'(y0);
        cmd_x1 = 9'(x1); cmd_y1 = 8'(y1); cmd_color = c; cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("issue_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_x0 = 9'($urandom); cmd_y0 = 8'($urandom);
        cmd_x1 = 9'($urandom); cmd_y1 = 8'($urandom); cmd_color = 1'($urandom);
    endtask

    // cyc = k when done is first seen after accept edge T+k.
    task automatic wait_done(input int bound, output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 || cyc > bound) break;
            cyc++;
        end
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input int x0, input int y0,
                           input int x1, input int y1, input logic c, input int n_lit);
        int n, cyc;
        if (n_lit >= 0) n = n_lit;
        else push_model(op, x0, y0, x1, y1, c, n);
        issue(op, x0, y0, x1, y1, c);
        wait_done(n + 10, cyc);
        chk({tag, "_done_cycle"}, cyc, n + 2);
        chk({tag, "_busy_at_done"}, busy, 1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_ready_back"}, cmd_ready, 1);
        chk({tag, "_busy_off"}, busy, 0);
        chk({tag, "_sb_drained"}, sb.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, w, cyc;

        // Reset held with a command waiting
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_x0 = 9'd5; cmd_y0 = 8'd1; cmd_color = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_we", fb_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", fb_addr, 0);
        chk("rst_din", fb_din, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready_release", cmd_ready, 1);
        cmd_valid = 1'b0;
        @(negedge clk);

        push_exp(325, 1'b1);
        run_cmd("plot", 2'b00, 5, 1, 0, 0, 1'b1, 1);

        push_exp(1610, 1'b1); push_exp(1611, 1'b1); push_exp(1612, 1'b1);
        push_exp(1930, 1'b1); push_exp(1931, 1'b1); push_exp(1932, 1'b1);
        run_cmd("rect", 2'b01, 10, 5, 12, 6, 1'b1, 6);

        run_cmd("rect_inverted", 2'b01, 5, 5, 3, 9, 1'b1, 0);

        push_exp(63678, 1'b1); push_exp(63679, 1'b1);
        push_exp(63998, 1'b1); push_exp(63999, 1'b1);
        run_cmd("rect_clamp", 2'b01, 318, 198, 400, 250, 1'b1, 4);

        run_cmd("plot_oob", 2'b00, 320, 0, 0, 0, 1'b1, 0);
        run_cmd("nop", 2'b11, 1, 1, 5, 5, 1'b1, 0);
        run_cmd("rect_bank_cross", 2'b01, 0, 51, 319, 51, 1'b0, -1);
        run_cmd("rect_clip_x", 2'b01, 300, 10, 330, 12, 1'b1, -1);

        base = n_wr;
        run_cmd("clear", 2'b10, 0, 0, 0, 0, 1'b0, -1);
        chk("clear_count", n_wr - base, 64000);

        // Reset in the middle of a CLEAR
        push_model(2'b10, 0, 0, 0, 0, 1'b1, n);
        base = n_wr;
        issue(2'b10, 0, 0, 0, 0, 1'b1);
        w = 0;
        while (n_wr - base < 1000 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("abort_reached", (n_wr - base >= 1000), 1);
        #1 reset = 1'b0;
        #1;
        chk("abort_we", fb_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        base = n_wr;
        @(negedge clk);
        chk("abort_ready_release", cmd_ready, 1);
        repeat (4) @(negedge clk);
        chk("abort_no_writes", n_wr - base, 0);

        // Valid held through busy: second command waits for ready
        push_exp(3 * 320 + 7, 1'b1);
        push_exp(4 * 320 + 9, 1'b0);
        @(negedge clk);
        cmd_op = 2'b00; cmd_x0 = 9'd7; cmd_y0 = 8'd3; cmd_color = 1'b1; cmd_valid = 1'b1;
        chk("hold_ready_first", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_x0 = 9'd9; cmd_y0 = 8'd4; cmd_color = 1'b0;
        wait_done(20, cyc);
        chk("hold_first_done", cyc, 3);
        chk("hold_ready_during_done", cmd_ready, 0);
        @(negedge clk);
        chk("hold_ready_second", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_done(20, cyc);
        chk("hold_second_done", cyc, 3);
        @(negedge clk);
        chk("hold_sb_drained", sb.size(), 0);
        chk("hold_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
